// File: rtl/down_counter_pkg.sv
// Shared types and constants for the down_counter block.
package down_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned TC_CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

endpackage : down_counter_pkg

// File: rtl/dc_event_counter.sv
// Wrapping 4-bit event counter; clear has priority over increment.
module dc_event_counter
    import down_counter_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    inc,
    output logic [TC_CNT_WIDTH-1:0] count
);

    // Count events, wrapping naturally from 15 back to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + TC_CNT_WIDTH'(1);
        end
    end

endmodule : dc_event_counter

// File: rtl/down_counter.sv
// Loadable down counter with pause, auto-reload and terminal-count tally.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [WIDTH-1:0]        load_value,
    input  logic                    enable,
    input  logic                    auto_reload,
    output logic [WIDTH-1:0]        count,
    output logic                    busy,
    output logic                    tc,
    output logic [TC_CNT_WIDTH-1:0] tc_cnt
);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] reload_n;
    logic [WIDTH-1:0] count_n;
    logic             tc_n;
    logic             tc_clr_c;
    logic             tc_inc_c;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            tc     <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            reload <= reload_n;
            tc     <= tc_n;
            busy   <= (state_n != IDLE);
        end
    end

    // Next-state logic: load beats a decrement; IDLE ignores enable.
    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload;
        tc_n     = 1'b0;
        tc_clr_c = 1'b0;
        tc_inc_c = 1'b0;

        if (load) begin
            count_n  = load_value;
            tc_clr_c = 1'b1;
            if (load_value != '0) begin
                reload_n = load_value;
                state_n  = RUN;
            end else begin
                state_n  = IDLE;
            end
        end else begin
            unique case (state)
                RUN, PAUSED: begin
                    if (enable) begin
                        state_n = RUN;
                        if (count > WIDTH'(1)) begin
                            count_n = count - WIDTH'(1);
                        end else if (count == WIDTH'(1)) begin
                            tc_n     = 1'b1;
                            tc_inc_c = 1'b1;
                            if (auto_reload) begin
                                count_n = reload;
                            end else begin
                                count_n = '0;
                                state_n = IDLE;
                            end
                        end else begin
                            // A zero count while active is unreachable; park safely.
                            state_n = IDLE;
                        end
                    end else begin
                        state_n = PAUSED;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Terminal-count tally since the last load.
    dc_event_counter u_tc_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (tc_clr_c),
        .inc   (tc_inc_c),
        .count (tc_cnt)
    );

endmodule : down_counter

// File: tb/tb_down_counter.sv
// Scoreboarded bench for down_counter: reference model plus directed scenarios.
module tb_down_counter;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             enable;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic [3:0]       tc_cnt;

    typedef struct {
        int count;
        int busy;
        int tc;
        int tc_cnt;
    } exp_t;

    exp_t sb[$];

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state (0 idle, 1 run, 2 paused).
    int m_state  = 0;
    int m_count  = 0;
    int m_reload = 0;
    int m_tc     = 0;
    int m_tccnt  = 0;

    int exp33[5] = '{4, 3, 2, 1, 0};
    int exp34[9] = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
    int exp35[4] = '{3, 3, 3, 2};
    int en35[4]  = '{1, 0, 0, 1};

    down_counter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_value  (load_value),
        .enable      (enable),
        .auto_reload (auto_reload),
        .count       (count),
        .busy        (busy),
        .tc          (tc),
        .tc_cnt      (tc_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_edge(input bit r, input bit l, input int lv, input bit e, input bit ar);
        m_tc = 0;
        if (r) begin
            m_state = 0; m_count = 0; m_reload = 0; m_tccnt = 0;
        end else if (l) begin
            m_count = lv;
            m_tccnt = 0;
            if (lv != 0) begin
                m_reload = lv;
                m_state  = 1;
            end else begin
                m_state = 0;
            end
        end else if (m_state != 0) begin
            if (!e) begin
                m_state = 2;
            end else if (m_count == 1) begin
                m_tc    = 1;
                m_tccnt = (m_tccnt + 1) % 16;
                if (ar) begin
                    m_count = m_reload;
                    m_state = 1;
                end else begin
                    m_count = 0;
                    m_state = 0;
                end
            end else begin
                m_count = m_count - 1;
                m_state = 1;
            end
        end
    endtask

    // Drive one cycle, queue the model's prediction, compare after the edge.
    task automatic step(input bit r, input bit l, input int lv, input bit e, input bit ar);
        exp_t x;
        reset       = r;
        load        = l;
        load_value  = WIDTH'(lv);
        enable      = e;
        auto_reload = ar;
        model_edge(r, l, lv, e, ar);
        x.count  = m_count;
        x.busy   = (m_state != 0) ? 1 : 0;
        x.tc     = m_tc;
        x.tc_cnt = m_tccnt;
        sb.push_back(x);
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            x = sb.pop_front();
            chk("m_count",  32'(count),  32'(x.count));
            chk("m_busy",   32'(busy),   32'(x.busy));
            chk("m_tc",     32'(tc),     32'(x.tc));
            chk("m_tc_cnt", 32'(tc_cnt), 32'(x.tc_cnt));
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; load_value = '0; enable = 1'b0; auto_reload = 1'b0;

        // Reset state.
        step(1, 0, 0, 0, 0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_tc",    32'(tc),    32'd0);

        // Load 5 and count down to terminal count.
        step(0, 1, 5, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 0);
            chk("s33_count", 32'(count), 32'(exp33[i]));
            chk("s33_tc",    32'(tc),    (i == 4) ? 32'd1 : 32'd0);
            chk("s33_busy",  32'(busy),  (i == 4) ? 32'd0 : 32'd1);
        end
        chk("s33_tc_cnt", 32'(tc_cnt), 32'd1);

        // Auto-reload with period 3.
        step(0, 1, 3, 0, 1);
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 0, 1, 1);
            chk("s34_count", 32'(count), 32'(exp34[i]));
            chk("s34_tc",    32'(tc),    (i % 3 == 2) ? 32'd1 : 32'd0);
            chk("s34_busy",  32'(busy),  32'd1);
        end
        chk("s34_tc_cnt", 32'(tc_cnt), 32'd3);

        // Pause and resume.
        step(0, 1, 4, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, en35[i][0], 0);
            chk("s35_count", 32'(count), 32'(exp35[i]));
            chk("s35_tc",    32'(tc),    32'd0);
            chk("s35_busy",  32'(busy),  32'd1);
        end

        // Load colliding with terminal count wins.
        step(0, 1, 2, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("s36_pre", 32'(count), 32'd1);
        step(0, 1, 7, 1, 0);
        chk("s36_count",  32'(count),  32'd7);
        chk("s36_tc",     32'(tc),     32'd0);
        chk("s36_tc_cnt", 32'(tc_cnt), 32'd0);
        chk("s36_busy",   32'(busy),   32'd1);

        // Reset mid-run aborts; enable then has no effect.
        step(0, 1, 6, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        chk("s37_count", 32'(count), 32'd0);
        chk("s37_busy",  32'(busy),  32'd0);
        chk("s37_tc",    32'(tc),    32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        chk("s37_idle", 32'(count), 32'd0);

        // Reset together with load; then load of zero stays idle.
        step(0, 1, 5, 0, 0);
        step(1, 1, 9, 1, 0);
        chk("rl_count", 32'(count), 32'd0);
        chk("rl_busy",  32'(busy),  32'd0);
        step(0, 1, 0, 1, 0);
        chk("l0_busy", 32'(busy), 32'd0);
        step(0, 0, 0, 1, 1);
        chk("l0_tc", 32'(tc), 32'd0);

        // auto_reload sampled only at terminal count.
        step(0, 1, 2, 0, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        chk("ar_stop", 32'(busy), 32'd0);

        // Reload value 1: tc every enabled cycle, tc_cnt wraps.
        step(0, 1, 1, 0, 1);
        for (int i = 0; i < 17; i++) begin
            step(0, 0, 0, 1, 1);
            chk("s38_tc", 32'(tc), 32'd1);
            if (i == 15) chk("s38_wrap0", 32'(tc_cnt), 32'd0);
        end
        chk("s38_wrap1", 32'(tc_cnt), 32'd1);

        // Paused at count 1, resume into terminal count.
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("pz_tc", 32'(tc), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_down_counter
